// File: rtl/fifo_write_arbiter_if.sv
// ----------------------------------------------------------------------------
// Module : fifo_write_arbiter_if
// Requester-side and FIFO-write-side signals of the shared write-port arbiter.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface fifo_write_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  logic [N_REQ-1:0]       req_in;
  logic [N_REQ*WIDTH-1:0] data_in;
  logic                   full_in;
  logic [N_REQ-1:0]       grant_out;
  logic                   write_out;
  logic [WIDTH-1:0]       data_write_out;
  logic [N_REQ-1:0]       ack_out;

  modport master (
    input  req_in, data_in, full_in,
    output grant_out, write_out, data_write_out, ack_out
  );

  modport slave (
    output req_in, data_in, full_in,
    input  grant_out, write_out, data_write_out, ack_out
  );
endinterface

`default_nettype wire

// File: rtl/fifo_write_arbiter.sv
// ----------------------------------------------------------------------------
// Module : fifo_write_arbiter
// Round-robin, burst-bounded arbiter sharing one FIFO write port among N_REQ.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fifo_write_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input wire logic             clk_in,
  input wire logic             nrst_in,
  fifo_write_arbiter_if.master bus
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] C_LAST    = CNT_W'(MAX_BURST - 1);
  localparam logic [PTR_W-1:0] C_PTR_MAX = PTR_W'(N_REQ - 1);
  localparam logic [N_REQ-1:0] C_ONE     = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [PTR_W-1:0] r_rr_ptr, w_rr_ptr_nxt;
  logic [CNT_W-1:0] r_burst_cnt, w_burst_cnt_nxt;
  logic [N_REQ-1:0] r_grant, w_grant_nxt;
  logic [PTR_W-1:0] w_gidx;
  logic [PTR_W-1:0] w_pick;
  logic             w_found;
  logic             w_write;
  logic             w_release;
  logic [WIDTH-1:0] w_gdata;

  always_comb begin
    w_gidx  = '0;
    w_gdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_grant[i]) begin
        w_gidx  = PTR_W'(i);
        w_gdata = bus.data_in[i*WIDTH +: WIDTH];
      end
    end
  end

  // First requesting index at or after r_rr_ptr, wrapping at N_REQ.
  always_comb begin
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_pick  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(r_rr_ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!w_found && bus.req_in[PTR_W'(idx)]) begin
        w_found = 1'b1;
        w_pick  = PTR_W'(idx);
      end
    end
  end

  assign w_write            = (r_state == ST_BURST) & bus.req_in[w_gidx] & ~bus.full_in;
  assign bus.write_out      = w_write;
  assign bus.grant_out      = r_grant;
  assign bus.ack_out        = r_grant & {N_REQ{w_write}};
  assign bus.data_write_out = (r_state == ST_BURST) ? w_gdata : '0;

  always_comb begin
    w_state_nxt     = r_state;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_burst_cnt_nxt = r_burst_cnt;
    w_grant_nxt     = r_grant;
    w_release       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_grant_nxt     = C_ONE << w_pick;
          w_burst_cnt_nxt = '0;
          w_state_nxt     = ST_BURST;
        end
      end
      ST_BURST: begin
        // A full FIFO with the request still up is a pure stall: nothing moves.
        if (w_write) begin
          w_burst_cnt_nxt = r_burst_cnt + 1'b1;
          if (r_burst_cnt == C_LAST) w_release = 1'b1;
        end else if (!bus.req_in[w_gidx]) begin
          w_release = 1'b1;
        end
        if (w_release) begin
          w_grant_nxt  = '0;
          w_rr_ptr_nxt = (w_gidx == C_PTR_MAX) ? '0 : w_gidx + 1'b1;
          w_state_nxt  = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
      r_grant     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
      r_grant     <= w_grant_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
// ----------------------------------------------------------------------------
// Module : tb_fifo_write_arbiter
// Directed scenarios plus a randomized soak against a behavioural arbiter model.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fifo_write_arbiter;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fifo_write_arbiter_if #(.N_REQ(4), .WIDTH(8)) bus4 ();
  fifo_write_arbiter_if #(.N_REQ(4), .WIDTH(8)) bus1 ();

  fifo_write_arbiter #(.N_REQ(4), .WIDTH(8), .MAX_BURST(4)) dut4 (
    .clk_in (clk),
    .nrst_in(nrst),
    .bus    (bus4.master)
  );

  fifo_write_arbiter #(.N_REQ(4), .WIDTH(8), .MAX_BURST(1)) dut1 (
    .clk_in (clk),
    .nrst_in(nrst),
    .bus    (bus1.master)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_inputs();
    bus4.req_in = '0; bus4.data_in = '0; bus4.full_in = 1'b0;
    bus1.req_in = '0; bus1.data_in = '0; bus1.full_in = 1'b0;
  endtask

  task automatic apply_reset();
    nrst = 1'b0;
    zero_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    bus4.req_in = 4'hF; bus4.data_in = 32'hA3A2A1A0; bus4.full_in = 1'b0;
    bus1.req_in = 4'hF; bus1.data_in = 32'hC3C2C1C0; bus1.full_in = 1'b0;
    tick();
    tick();
    checks++; if (bus4.grant_out !== 4'b0) begin errors++; $display("FAIL reset_grant4 got %b want 0000", bus4.grant_out); end
    checks++; if (bus4.write_out !== 1'b0) begin errors++; $display("FAIL reset_write4 got %b want 0", bus4.write_out); end
    checks++; if (bus4.ack_out !== 4'b0) begin errors++; $display("FAIL reset_ack4 got %b want 0000", bus4.ack_out); end
    checks++; if (bus4.data_write_out !== 8'h00) begin errors++; $display("FAIL reset_data4 got %h want 00", bus4.data_write_out); end
    checks++; if (bus1.grant_out !== 4'b0) begin errors++; $display("FAIL reset_grant1 got %b want 0000", bus1.grant_out); end
    checks++; if (bus1.write_out !== 1'b0) begin errors++; $display("FAIL reset_write1 got %b want 0", bus1.write_out); end
  endtask

  // Requester 2 alone: 4-word burst, one idle cycle, 2 more words, release, then rr_ptr=3.
  task automatic test_single_requester();
    logic [3:0] t_req [13];
    logic [7:0] t_w   [13];
    logic [3:0] t_g   [13];
    logic       t_wr  [13];
    logic [7:0] t_dw  [13];
    t_req = '{4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0};
    t_w   = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd5, 8'd6, 8'd6, 8'd6, 8'd6, 8'd6, 8'd6};
    t_g   = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h0};
    t_wr  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    t_dw  = '{8'h00, 8'd1, 8'd2, 8'd3, 8'd4, 8'h00, 8'd5, 8'd6, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h00};
    apply_reset();
    for (int i = 0; i < 13; i++) begin
      tick();
      bus4.req_in  = t_req[i];
      bus4.data_in = {8'hB3, t_w[i], 8'hB1, 8'hB0};
      #1;
      checks++; if (bus4.grant_out !== t_g[i]) begin errors++; $display("FAIL single_grant c%0d got %b want %b", i, bus4.grant_out, t_g[i]); end
      checks++; if (bus4.write_out !== t_wr[i]) begin errors++; $display("FAIL single_write c%0d got %b want %b", i, bus4.write_out, t_wr[i]); end
      checks++; if (bus4.ack_out !== (t_wr[i] ? t_g[i] : 4'h0)) begin errors++; $display("FAIL single_ack c%0d got %b want %b", i, bus4.ack_out, (t_wr[i] ? t_g[i] : 4'h0)); end
      if (t_wr[i] || t_g[i] == 4'h0) begin
        checks++; if (bus4.data_write_out !== t_dw[i]) begin errors++; $display("FAIL single_data c%0d got %h want %h", i, bus4.data_write_out, t_dw[i]); end
      end
    end
  endtask

  task automatic test_round_robin();
    int         ord [3];
    logic [3:0] e_g;
    ord = '{0, 1, 3};
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      tick();
      bus1.req_in  = 4'b1011;
      bus1.data_in = 32'hC3C2C1C0;
      #1;
      e_g = (i % 2 == 0) ? 4'h0 : (4'h1 << ord[((i - 1) / 2) % 3]);
      checks++; if (bus1.grant_out !== e_g) begin errors++; $display("FAIL rr_grant c%0d got %b want %b", i, bus1.grant_out, e_g); end
      checks++; if (bus1.write_out !== (e_g != 4'h0)) begin errors++; $display("FAIL rr_write c%0d got %b want %b", i, bus1.write_out, (e_g != 4'h0)); end
      if (e_g != 4'h0) begin
        checks++; if (bus1.data_write_out !== 8'hC0 + 8'(ord[((i - 1) / 2) % 3])) begin errors++; $display("FAIL rr_data c%0d got %h want %h", i, bus1.data_write_out, 8'hC0 + 8'(ord[((i - 1) / 2) % 3])); end
      end
    end
  endtask

  // Grant to 0, full for 5 cycles after the second write, then exactly 2 more writes.
  task automatic test_full_stall();
    logic       t_full [12];
    logic [7:0] t_w    [12];
    logic [3:0] t_g    [12];
    logic       t_wr   [12];
    t_full = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    t_w    = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd4, 8'd5, 8'd5};
    t_g    = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h1};
    t_wr   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      tick();
      bus4.req_in  = 4'h1;
      bus4.full_in = t_full[i];
      bus4.data_in = {8'hB3, 8'hB2, 8'hB1, t_w[i]};
      #1;
      checks++; if (bus4.grant_out !== t_g[i]) begin errors++; $display("FAIL stall_grant c%0d got %b want %b", i, bus4.grant_out, t_g[i]); end
      checks++; if (bus4.write_out !== t_wr[i]) begin errors++; $display("FAIL stall_write c%0d got %b want %b", i, bus4.write_out, t_wr[i]); end
      checks++; if (bus4.ack_out !== (t_wr[i] ? t_g[i] : 4'h0)) begin errors++; $display("FAIL stall_ack c%0d got %b want %b", i, bus4.ack_out, (t_wr[i] ? t_g[i] : 4'h0)); end
      if (t_wr[i]) begin
        checks++; if (bus4.data_write_out !== t_w[i]) begin errors++; $display("FAIL stall_data c%0d got %h want %h", i, bus4.data_write_out, t_w[i]); end
      end
    end
  endtask

  // Requester 2 drops after 2 words; next grant wraps from 3 to requester 0.
  task automatic test_early_release();
    logic [3:0] t_req [8];
    logic [7:0] t_w   [8];
    logic [3:0] t_g   [8];
    logic       t_wr  [8];
    logic [7:0] t_dw  [8];
    t_req = '{4'h4, 4'h4, 4'h4, 4'h1, 4'h3, 4'h3, 4'h0, 4'h0};
    t_w   = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3};
    t_g   = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h1, 4'h1, 4'h0};
    t_wr  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    t_dw  = '{8'h00, 8'd1, 8'd2, 8'h00, 8'h00, 8'hB0, 8'h00, 8'h00};
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      tick();
      bus4.req_in  = t_req[i];
      bus4.data_in = {8'hB3, t_w[i], 8'hB1, 8'hB0};
      #1;
      checks++; if (bus4.grant_out !== t_g[i]) begin errors++; $display("FAIL early_grant c%0d got %b want %b", i, bus4.grant_out, t_g[i]); end
      checks++; if (bus4.write_out !== t_wr[i]) begin errors++; $display("FAIL early_write c%0d got %b want %b", i, bus4.write_out, t_wr[i]); end
      checks++; if (bus4.ack_out !== (t_wr[i] ? t_g[i] : 4'h0)) begin errors++; $display("FAIL early_ack c%0d got %b want %b", i, bus4.ack_out, (t_wr[i] ? t_g[i] : 4'h0)); end
      if (t_wr[i] || t_g[i] == 4'h0) begin
        checks++; if (bus4.data_write_out !== t_dw[i]) begin errors++; $display("FAIL early_data c%0d got %h want %h", i, bus4.data_write_out, t_dw[i]); end
      end
    end
  endtask

  // Runs straight after test_early_release, so rr_ptr is 1 going in.
  task automatic test_reset_mid_burst();
    for (int i = 0; i < 4; i++) begin
      tick();
      bus4.req_in  = 4'h4;
      bus4.data_in = {8'hB3, 8'(i), 8'hB1, 8'hB0};
      #1;
      checks++; if (bus4.grant_out !== ((i == 0) ? 4'h0 : 4'h4)) begin errors++; $display("FAIL midrst_grant c%0d got %b want %b", i, bus4.grant_out, ((i == 0) ? 4'h0 : 4'h4)); end
      checks++; if (bus4.write_out !== (i != 0)) begin errors++; $display("FAIL midrst_write c%0d got %b want %b", i, bus4.write_out, (i != 0)); end
    end
    #1 nrst = 1'b0;
    #1;
    checks++; if (bus4.grant_out !== 4'h0) begin errors++; $display("FAIL midrst_async_grant got %b want 0000", bus4.grant_out); end
    checks++; if (bus4.write_out !== 1'b0) begin errors++; $display("FAIL midrst_async_write got %b want 0", bus4.write_out); end
    checks++; if (bus4.ack_out !== 4'h0) begin errors++; $display("FAIL midrst_async_ack got %b want 0000", bus4.ack_out); end
    checks++; if (bus4.data_write_out !== 8'h00) begin errors++; $display("FAIL midrst_async_data got %h want 00", bus4.data_write_out); end
    bus4.req_in = 4'h0;
    @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    tick();
    bus4.req_in = 4'hF;
    #1;
    checks++; if (bus4.grant_out !== 4'h0) begin errors++; $display("FAIL midrst_idle_grant got %b want 0000", bus4.grant_out); end
    tick();
    #1;
    checks++; if (bus4.grant_out !== 4'h1) begin errors++; $display("FAIL midrst_rrptr_grant got %b want 0001", bus4.grant_out); end
  endtask

  // Random req/full soak on both instances against a per-instance behavioural model.
  task automatic test_random_soak();
    logic [3:0]  req_v  [2];
    logic        full_v [2];
    logic [31:0] data_v [2];
    int          m_g    [2];
    int          m_cnt  [2];
    int          m_ptr  [2];
    int          mb     [2];
    logic [3:0]  o_g, o_ack, e_g, e_ack;
    logic        o_wr, e_wr, rel, found;
    logic [7:0]  o_dw, e_dw;
    int          r;
    apply_reset();
    mb = '{4, 1};
    for (int d = 0; d < 2; d++) begin
      m_g[d] = -1; m_cnt[d] = 0; m_ptr[d] = 0;
      req_v[d] = '0; full_v[d] = 1'b0;
      data_v[d] = (d == 0) ? 32'hA3A2A1A0 : $urandom;
    end
    for (int cyc = 0; cyc < 500; cyc++) begin
      tick();
      bus4.req_in = req_v[0]; bus4.full_in = full_v[0]; bus4.data_in = data_v[0];
      bus1.req_in = req_v[1]; bus1.full_in = full_v[1]; bus1.data_in = data_v[1];
      #1;
      for (int d = 0; d < 2; d++) begin
        o_g   = (d == 0) ? bus4.grant_out      : bus1.grant_out;
        o_wr  = (d == 0) ? bus4.write_out      : bus1.write_out;
        o_ack = (d == 0) ? bus4.ack_out        : bus1.ack_out;
        o_dw  = (d == 0) ? bus4.data_write_out : bus1.data_write_out;
        e_g   = (m_g[d] >= 0) ? (4'h1 << m_g[d]) : 4'h0;
        e_wr  = (m_g[d] >= 0) && req_v[d][m_g[d]] && !full_v[d];
        e_ack = e_wr ? e_g : 4'h0;
        e_dw  = (m_g[d] >= 0) ? data_v[d][m_g[d]*8 +: 8] : 8'h00;
        checks++; if (o_g !== e_g) begin errors++; $display("FAIL soak_grant d%0d cyc%0d got %b want %b", d, cyc, o_g, e_g); end
        checks++; if (o_wr !== e_wr) begin errors++; $display("FAIL soak_write d%0d cyc%0d got %b want %b", d, cyc, o_wr, e_wr); end
        checks++; if (o_ack !== e_ack) begin errors++; $display("FAIL soak_ack d%0d cyc%0d got %b want %b", d, cyc, o_ack, e_ack); end
        if (e_wr || m_g[d] < 0) begin
          checks++; if (o_dw !== e_dw) begin errors++; $display("FAIL soak_data d%0d cyc%0d got %h want %h", d, cyc, o_dw, e_dw); end
        end
        checks++; if (o_wr === 1'b1 && full_v[d]) begin errors++; $display("FAIL soak_write_on_full d%0d cyc%0d got write 1 want 0", d, cyc); end
        // Model advance at the coming edge.
        if (m_g[d] < 0) begin
          found = 1'b0;
          for (int k = 0; k < 4; k++) begin
            r = (m_ptr[d] + k) % 4;
            if (!found && req_v[d][r]) begin found = 1'b1; m_g[d] = r; m_cnt[d] = 0; end
          end
        end else begin
          rel = 1'b0;
          if (e_wr) begin
            m_cnt[d]++;
            if (m_cnt[d] == mb[d]) rel = 1'b1;
          end else if (!req_v[d][m_g[d]]) begin
            rel = 1'b1;
          end
          if (rel) begin m_ptr[d] = (m_g[d] + 1) % 4; m_g[d] = -1; end
        end
        // Requesters hold until acked, then may continue with fresh data or drop.
        for (int k = 0; k < 4; k++) begin
          if (e_ack[k]) begin
            req_v[d][k] = 1'($urandom_range(0, 1));
            data_v[d][k*8 +: 8] = (d == 0) ? (8'hA0 + 8'(k)) : 8'($urandom);
          end else if (!req_v[d][k]) begin
            req_v[d][k] = ($urandom_range(0, 9) < 3);
          end
        end
        full_v[d] = ($urandom_range(0, 3) == 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_requester();
    test_round_robin();
    test_full_stall();
    test_early_release();
    test_reset_mid_burst();
    test_random_soak();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin arbiter that shares the write port of the asynchronous circular FIFO between N_REQ requesters. It sits entirely in the write clock domain, in front of the FIFO's write_in/data_write_in/full_out interface. It grants one requester at a time for a bounded burst and stalls on FIFO full. Grants rotate fairly among active requesters.

## Interface
One clock; reset is asynchronous and active-low.
- N_REQ, 4: number of requesters, ≥2.
- WIDTH, 8: data word width; matches FIFO WIDTH.
- MAX_BURST, 4: maximum words written per grant, ≥1.
- clk_in  input  1  FIFO write clock.
- nrst_in  input  1  asynchronous active-low reset.
- req_in  input  N_REQ  bit r high = requester r has a word on its data slice.
- data_in  input  N_REQ*WIDTH  requester r word at bits [r*WIDTH +: WIDTH].
- full_in  input  1  FIFO full flag (write domain).
- grant_out  output  N_REQ  registered one-hot grant; all-zero when idle.
- write_out  output  1  FIFO write strobe (to write_in).
- data_write_out  output  WIDTH  word to FIFO (to data_write_in).
- ack_out  output  N_REQ  bit r high = requester r's word is consumed this cycle.

## Operation
- State: FSM {IDLE, BURST}, rr_ptr (clog2(N_REQ) bits), burst_cnt (clog2(MAX_BURST)+1 bits), grant_out register.
- IDLE: grant_out=0, write_out=0. If req_in≠0, the new grant goes to the first r with req_in[r]=1, scanning from rr_ptr upward and wrapping at N_REQ. Then grant_out←one-hot(r), burst_cnt←0, next state BURST. If req_in=0, stay in IDLE.
- BURST with granted index g:
  - Combinational outputs: write_out = req_in[g] & ~full_in; ack_out = grant_out & {N_REQ{write_out}}; data_write_out = data_in slice g.
  - When a write occurs, burst_cnt increments.
- Release from BURST to IDLE:
  - (a) req_in[g]=0, with no write that cycle; or
  - (b) a write occurs while burst_cnt = MAX_BURST-1.
  - On release: grant_out←0, rr_ptr←(g+1) mod N_REQ.
- full_in=1 in BURST: no write; burst_cnt, grant and rr_ptr hold. Stall length is unbounded, and the grant is not revoked.
- full_in and req_in[g]=0 together: release (a) applies.
- data_write_out is don't-care when write_out=0. It is driven as slice g in BURST and as 0 in IDLE.
- Requesters must hold req_in/data stable until ack. Changes to req_in of non-granted requesters never affect the current burst.
- Reset mid-burst: all state clears immediately and asynchronously. The partial burst is abandoned; words already written stay in the FIFO.

## Timing
- Reset values: grant_out=0, write_out=0, ack_out=0, data_write_out=0, state IDLE, rr_ptr=0, burst_cnt=0.
- Arbitration latency: req_in rising in IDLE at edge k gives grant_out valid after edge k+1; the first write is possible in cycle k+1.
- Throughput: up to MAX_BURST consecutive writes per grant, followed by exactly one IDLE cycle between grants.
- A FIFO with full_in=0 throughout accepts one word per cycle within a burst.
- Zero-latency ack: the requester sees ack_out in the same cycle as write_out. It presents its next word from the following edge.
- The RTL never asserts write_out while full_in=1.

## Test plan
- Reset then single requester: req_in=4'b0100 held with 6 words, full_in=0, MAX_BURST=4.
  - Required: grant_out=4'b0100 one cycle after the request.
  - Required: write_out high 4 cycles with words 1-4, then 1 IDLE cycle, re-grant to 2, words 5-6.
  - Required: release on deassert; rr_ptr=3 afterwards.
- Round-robin: req_in=4'b1011 all continuously requesting, MAX_BURST=1 → grant order 0,1,3,0,1,3, each grant separated by one IDLE cycle.
- Full stall: grant to 0, full_in=1 for 5 cycles after the second write.
  - Required: write_out=0 and grant held throughout; burst_cnt stays 2.
  - Required: after full_in falls, exactly 2 more writes before release.
- Early release: requester 2 deasserts after 2 of MAX_BURST=4 words → release with no spurious write, rr_ptr=3, next grant to the lowest pending requester ≥3 (wrapping).
- Reset mid-burst: nrst_in low during the third write cycle → grant_out, write_out and ack_out are 0 immediately, and rr_ptr=0 after reset release.
- Data routing: N_REQ=4, data_in slices 8'hA0..8'hA3 → each write carries 8'hA0+g matching grant_out; no write occurs while full_in=1 (assertion checked over a random req/full soak).
